// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access unit for the multicycle RV32I core.
// Turns one controller request (fetch, load or store) into a word-aligned
// bus transaction with byte enables, waits for the bus to complete it
// (bounded by a timeout), and returns sign/zero-extended load data.
//
// Handshakes:
//   controller side - req is held high until done pulses for one cycle;
//                     stall = req & ~done keeps the controller parked.
//   bus side        - mem_req is high for every BUSY cycle with stable
//                     mem_we/mem_addr/mem_wdata/mem_be; the transfer
//                     completes in the cycle mem_ready is high, and
//                     mem_rdata is valid in that same cycle.
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_cause,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   // The counter only needs to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_FUNCT3   = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lane_q, lane_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdat_q, wdat_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        cause_q, cause_d;

   logic              f3_illegal;
   logic              misaligned;
   logic [3:0]        be_next;
   logic [31:0]       wdat_next;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_ext;

   // Legality of the incoming request; an illegal funct3 outranks misalignment.
   always_comb begin
      f3_illegal = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
         3'b100, 3'b101:         f3_illegal = we;
         default:                f3_illegal = 1'b1;
      endcase
      misaligned = 1'b0;
      if (funct3[1:0] == 2'b01) begin
         misaligned = addr[0];
      end else if (funct3[1:0] == 2'b10) begin
         misaligned = |addr[1:0];
      end
   end

   // Byte enables and lane-replicated store data for the incoming request.
   always_comb begin
      be_next   = 4'b1111;
      wdat_next = wdata;
      if (we) begin
         case (funct3[1:0])
            2'b00: begin
               be_next   = 4'b0001 << addr[1:0];
               wdat_next = {4{wdata[7:0]}};
            end
            2'b01: begin
               be_next   = addr[1] ? 4'b1100 : 4'b0011;
               wdat_next = {2{wdata[15:0]}};
            end
            default: begin
               be_next   = 4'b1111;
               wdat_next = wdata;
            end
         endcase
      end
   end

   // Lane selection and extension of bus read data, using the latched request.
   always_comb begin
      byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
      half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'b0, byte_sel};
         3'b101:  load_ext = {16'b0, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   // FSM next state and next values of every latched field.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      lane_d  = lane_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdat_d  = wdat_q;
      rdata_d = rdata_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (f3_illegal) begin
                  state_d = S_ERR;
                  cause_d = CAUSE_FUNCT3;
               end else if (misaligned) begin
                  state_d = S_ERR;
                  cause_d = CAUSE_MISALIGN;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = '0;
                  we_d    = we;
                  f3_d    = funct3;
                  lane_d  = addr[1:0];
                  addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  be_d    = be_next;
                  wdat_d  = wdat_next;
               end
            end
         end
         S_BUSY: begin
            if (mem_ready) begin
               rdata_d = load_ext;
               state_d = S_DONE;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d = S_ERR;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched fields; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         lane_q  <= 2'b00;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdat_q  <= 32'h0;
         rdata_q <= 32'h0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdat_q  <= wdat_d;
         rdata_q <= rdata_d;
         cause_q <= cause_d;
      end
   end

   assign mem_req   = (state_q == S_BUSY);
   assign done      = (state_q == S_DONE) || (state_q == S_ERR);
   assign err       = (state_q == S_ERR);
   assign stall     = req & ~done;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdat_q;
   assign rdata     = rdata_q;
   assign err_cause = cause_q;
   assign dbg_state = state_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store memory access unit for the multicycle RV32I core. It sits directly downstream of the controller and turns each memory request (fetch, load or store) into a word-aligned bus transaction with byte enables, wait-state handshaking and a timeout. Loads are returned sign- or zero-extended, and a stall output holds the controller in its current state until the access completes.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- TIMEOUT, 16, maximum cycles spent in BUSY waiting for `mem_ready`; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  access request from the controller; held high until `done`
- we  in  1  1 = store, 0 = load/fetch
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned
- rdata  out  32  extended load data; valid while `done`=1
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with `done`
- err_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; holds until the next error
- stall  out  1  combinational: `req & ~done`
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word address; bits [1:0] are always 00
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  bus completion; read data is valid in the same cycle
- mem_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - `req`=1 and the access is legal → latch `we`, `funct3`, `addr[1:0]` and the bus fields, then go to BUSY.
  - `req`=1 and the access is illegal → go to ERR.
- Legality:
  - Half-word accesses need `addr[0]`=0; word accesses need `addr[1:0]`=00. Otherwise the cause is misaligned.
  - Stores accept only funct3 000/001/010; loads accept 000/001/010/100/101. Anything else is illegal funct3.
  - When both faults apply, illegal funct3 takes priority.
- BUSY: `mem_req`=1. On `mem_ready`, capture the extended `mem_rdata` into `rdata` and go to DONE. If the timeout counter reaches TIMEOUT−1 without `mem_ready`, go to ERR with cause 11.
- DONE: `done`=1 for one cycle, then go to IDLE.
- ERR: `done`=1, `err`=1, `mem_req`=0 for one cycle, then go to IDLE. `rdata` is unchanged.
- Byte enables and store data:
  - sb: `mem_be` = 0001 << `addr[1:0]`; `mem_wdata` = byte replicated ×4.
  - sh: `mem_be` = 0011 or 1100 selected by `addr[1]`; `mem_wdata` = half replicated ×2.
  - sw: `mem_be` = 1111.
  - Loads: `mem_be` = 1111, `mem_we`=0.
- Load extraction uses the latched `addr[1:0]`:
  - b/h select the lane, then sign-extend.
  - bu/hu select the lane, then zero-extend.
- A `req` drop while in BUSY does not abort the access; the bus transaction completes and `done` still pulses.
- A `req` seen in DONE or ERR is ignored. The next access is accepted from IDLE, no earlier than one cycle after `done`.

## Timing
- Reset state: FSM in IDLE. All of `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `rdata`, `done`, `err`, `err_cause` and the timeout counter are 0.
- Asserting `reset` mid-BUSY drops `mem_req` immediately (asynchronously). No `done` is produced.
- Latency with zero wait states (`mem_ready`=1 in the first BUSY cycle):
  - cycle 0: `req` seen in IDLE;
  - cycle 1: BUSY;
  - cycle 2: DONE.
  - `stall` is high in cycles 0–1 and low in cycle 2.
- Each wait state adds one cycle.
- Error path: ERR is reached in cycle 1, so `done`/`err` are high in cycle 1.
- Bus fields are registered and stable for the whole of BUSY. `mem_req` is deasserted in the cycle after `mem_ready`.
- Timeout counter: cleared on entry to BUSY and increments each BUSY cycle. With TIMEOUT=N, the access gives up after N cycles in BUSY without `mem_ready`.

## Test plan
- lw, addr 0x104, `mem_rdata` 0xDEADBEEF, ready in the first BUSY cycle → `mem_addr` 0x104, `mem_be` 1111, `done` in cycle 2, `rdata` 0xDEADBEEF, `stall` high for exactly 2 cycles.
- lb / lbu at addr 0x103, `mem_rdata` 0x80FF1234, 3 wait states → lb gives `rdata` 0xFFFFFF80, lbu gives 0x00000080; `done` in cycle 5.
- sh, addr 0x22, `wdata` 0x0000ABCD → `mem_we`=1, `mem_be` 1100, `mem_wdata` 0xABCDABCD, `mem_addr` 0x20.
- lw at addr 0x102 → no `mem_req`; `done`=`err`=1 in cycle 1; `err_cause` 01. Store with funct3 100 → `err_cause` 10.
- TIMEOUT=4, `mem_ready` held 0 → `mem_req` high for exactly 4 cycles, then `err` with cause 11; the next legal request completes normally.
- Assert `reset` during a BUSY wait → `mem_req` falls in the same cycle, all outputs read 0. After release, a new lw completes with 2-cycle latency.
